// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default geometry, the halt sentinel word, MIPS opcode constants shared with
// the decode side, and the branch displacement helper.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_e;

  localparam int          MEM_DEPTH_C = 128;
  localparam int          ADDR_W_C    = 7;
  localparam int          ISSUE_GAP_C = 2;
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_C = 32'hFFFF_FFFF;

  // Primary opcodes (instr[31:26]) and the R-type ADD function code.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;

  // Signed imm16 word offset -> 32-bit byte displacement.
  function automatic logic [31:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_imem.sv
// Instruction memory: DEPTH x 32 array, synchronous write, asynchronous read.
// Latency: read is combinational from raddr; write lands on the clock edge.
// Backpressure: none; the caller gates we. Contents are never reset.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module instr_fetch_unit_imem #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage for mipscpu: PC register, instruction memory, fetch FSM that
//   presents instrword and pulses newinstr once per instruction.
// Latency: run sampled high -> newinstr two edges later; period 2+ISSUE_GAP
//   cycles per instruction. Backpressure: stall holds the last WAIT cycle.
// Ports: clk/reset; run, stall, branch_taken/branch_offset (control);
//   imem_we/imem_waddr/imem_wdata (preload, IDLE/HALT only);
//   instrword/newinstr/pc (to CPU); busy/halted (status).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          MEM_DEPTH = MEM_DEPTH_C,
  parameter int          ADDR_W    = ADDR_W_C,
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter int          ISSUE_GAP = ISSUE_GAP_C,
  parameter logic [31:0] HALT_WORD = HALT_WORD_C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       instrword,
  output logic              newinstr,
  output logic [31:0]       pc,
  output logic              busy,
  output logic              halted
);

  // ISSUE_GAP counts every WAIT cycle including the exit cycle, so the
  // counter is loaded one short and the exit happens when it reads zero.
  localparam logic [3:0] GAP_LOAD = 4'(ISSUE_GAP - 1);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         newinstr_q;
  logic         busy_q;
  logic         halted_q;
  logic [3:0]   cnt_q;

  logic [31:0]  rd_word;
  logic [31:0]  pc_d;
  logic         pc_d_oob;
  logic         imem_wr_en;

  // Preload is only safe while the FSM is not walking the memory.
  assign imem_wr_en = imem_we && ((state_q == S_IDLE) || (state_q == S_HALT));

  instr_fetch_unit_imem #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk   (clk),
    .we    (imem_wr_en),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc_q[ADDR_W+1:2]),
    .rdata (rd_word)
  );

  // Sequential or PC-relative next address, 32-bit modulo. Anything with a
  // bit set above the imem byte range (incl. wrap below zero) is off the end.
  assign pc_d     = pc_q + 32'd4 + (branch_taken ? branch_disp(branch_offset) : 32'd0);
  assign pc_d_oob = |(pc_d >> (ADDR_W + 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      newinstr_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      newinstr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (rd_word == HALT_WORD) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            instr_q    <= rd_word;
            newinstr_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= GAP_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!stall) begin
            if (pc_d_oob) begin
              // Keep pc at the last issued word so the halt point is visible.
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (run) begin
                state_q <= S_FETCH;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        S_HALT: begin
          if (!run) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
          cnt_q    <= 4'd0;
        end
      endcase
    end
  end

  assign instrword = instr_q;
  assign newinstr  = newinstr_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule
